// File: rtl/mo_arb_pkg.sv
// mo_arb_pkg: shared sizes and state encoding for the mo_arb round-robin arbiter
package mo_arb_pkg;
    localparam int NREQ         = 5;
    localparam int MAX_HOLD_DEF = 16;
    localparam int CNT_W        = 5;
    localparam int ID_W         = 3;
    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;
endpackage

// File: rtl/mo_rr_pick.sv
// mo_rr_pick: combinational round-robin pick, first set req bit scanning from ptr with wrap
module mo_rr_pick
    import mo_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] pick,
    output logic [ID_W-1:0] idx,
    output logic            any
);
    logic [NREQ-1:0] rot;
    logic [ID_W-1:0] off;
    logic [ID_W:0]   sum;
    always_comb begin
        rot = NREQ'({req, req} >> ptr);
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) if (rot[i]) off = ID_W'(i);
        sum = {1'b0, ptr} + {1'b0, off};
        idx = (sum >= (ID_W + 1)'(NREQ)) ? ID_W'(sum - (ID_W + 1)'(NREQ)) : sum[ID_W-1:0];
        any = |req;
        pick = any ? NREQ'(1) << idx : '0;
    end
endmodule

// File: rtl/mo_arb.sv
// mo_arb: five-way round-robin DMA bus arbiter with per-grant beat limit and a dead cycle
// between owners; all outputs registered.
module mo_arb
    import mo_arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
)(
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [NREQ-1:0] req,
    input  logic            ack_i,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            busy,
    output logic            forced
);
    state_t          state, state_n;
    logic [ID_W-1:0] ptr, ptr_n, idx, id_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [NREQ-1:0] pick, gnt_n;
    logic            any, busy_n, forced_n, keep, lim;

    mo_rr_pick u_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick),
        .idx  (idx),
        .any  (any)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_i)
        if (!wb_rst_i) begin
            state  <= IDLE;
            ptr    <= '0;
            cnt    <= '0;
            gnt    <= '0;
            gnt_id <= '0;
            busy   <= 1'b0;
            forced <= 1'b0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            cnt    <= cnt_n;
            gnt    <= gnt_n;
            gnt_id <= id_n;
            busy   <= busy_n;
            forced <= forced_n;
        end

    // a release always lands in IDLE with gnt=0, which gives the dead cycle for free
    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        cnt_n    = cnt;
        gnt_n    = gnt;
        id_n     = gnt_id;
        busy_n   = busy;
        forced_n = 1'b0;
        keep     = |(req & gnt);
        lim      = ack_i && cnt == CNT_W'(MAX_HOLD - 1);
        if (state == IDLE) begin
            if (any) begin
                state_n = OWN;
                gnt_n   = pick;
                id_n    = idx;
                busy_n  = 1'b1;
                cnt_n   = '0;
            end
        end else if (!keep || lim) begin
            state_n  = IDLE;
            gnt_n    = '0;
            busy_n   = 1'b0;
            cnt_n    = '0;
            ptr_n    = (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + ID_W'(1);
            forced_n = keep;
        end else if (ack_i)
            cnt_n = cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_mo_arb.sv
// tb_mo_arb: table vectors, scoreboarded behavioural model and invariant checks for mo_arb
module tb_mo_arb;
    localparam int MAX_HOLD = 16;

    typedef struct packed {
        logic [4:0] gnt;
        logic [2:0] id;
        logic       busy;
        logic       forced;
    } out_t;

    typedef struct packed {
        logic       rst;
        logic [4:0] req;
        logic       ack;
        out_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] req = '0;
    logic       ack = 1'b0;
    logic [4:0] gnt;
    logic [2:0] gnt_id;
    logic       busy, forced;

    int n_cmp = 0;
    int n_bad = 0;
    out_t exp_q[$];
    vec_t tbl[$];

    logic [4:0] m_gnt;
    logic [2:0] m_id;
    logic       m_own, m_forced;
    int         m_ptr, m_cnt;

    mo_arb #(.MAX_HOLD(MAX_HOLD)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .req      (req),
        .ack_i    (ack),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .busy     (busy),
        .forced   (forced)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic rs, input logic [4:0] r, input logic a,
                               input logic [4:0] g, input logic [2:0] i, input logic b, input logic f);
        vec_t t;
        t.rst = rs; t.req = r; t.ack = a;
        t.exp.gnt = g; t.exp.id = i; t.exp.busy = b; t.exp.forced = f;
        return t;
    endfunction

    task automatic model_reset();
        m_gnt = '0; m_id = '0; m_own = 1'b0; m_forced = 1'b0; m_ptr = 0; m_cnt = 0;
    endtask

    task automatic model_release(input logic f);
        m_gnt = '0; m_own = 1'b0; m_cnt = 0; m_forced = f;
        m_ptr = (int'(m_id) + 1) % 5;
    endtask

    task automatic model_step(input logic [4:0] r, input logic a);
        int w;
        m_forced = 1'b0;
        if (!m_own) begin
            w = -1;
            for (int k = 0; k < 5; k++)
                if (w < 0 && r[(m_ptr + k) % 5]) w = (m_ptr + k) % 5;
            if (w >= 0) begin
                m_gnt = 5'b00001 << w;
                m_id = 3'(w);
                m_own = 1'b1;
                m_cnt = 0;
            end
        end else if (!r[m_id]) model_release(1'b0);
        else if (a && m_cnt == MAX_HOLD - 1) model_release(1'b1);
        else if (a) m_cnt++;
    endtask

    function automatic out_t model_out();
        out_t o;
        o.gnt = m_gnt; o.id = m_id; o.busy = (m_gnt != 0); o.forced = m_forced;
        return o;
    endfunction

    task automatic check(input string nm);
        out_t a, e;
        a = {gnt, gnt_id, busy, forced};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty, got gnt=%b id=%0d busy=%b forced=%b", nm, a.gnt, a.id, a.busy, a.forced);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got gnt=%b id=%0d busy=%b forced=%b, want gnt=%b id=%0d busy=%b forced=%b",
                         nm, a.gnt, a.id, a.busy, a.forced, e.gnt, e.id, e.busy, e.forced);
            end
        end
    endtask

    task automatic check_eq(input string nm, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, want);
        end
    endtask

    task automatic step(input logic [4:0] r, input logic a, input string nm);
        @(negedge clk);
        rst_n = 1'b1; req = r; ack = a;
        model_step(r, a);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1 check(nm);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = '0; ack = 1'b0;
        model_reset();
        exp_q.push_back(model_out());
        @(posedge clk);
        #1 check("reset");
    endtask

    initial begin
        logic [4:0] nr, pg;
        int w[5];
        int max_w, hi, fc;

        tbl.push_back(v(1, 5'b00100, 0, 5'b00000, 0, 0, 0));
        tbl.push_back(v(0, 5'b00100, 0, 5'b00100, 2, 1, 0));
        tbl.push_back(v(0, 5'b00100, 1, 5'b00100, 2, 1, 0));
        tbl.push_back(v(0, 5'b00000, 0, 5'b00000, 2, 0, 0));
        tbl.push_back(v(0, 5'b00000, 0, 5'b00000, 2, 0, 0));
        tbl.push_back(v(0, 5'b00101, 0, 5'b00001, 0, 1, 0));
        tbl.push_back(v(0, 5'b00000, 0, 5'b00000, 0, 0, 0));
        tbl.push_back(v(1, 5'b10011, 0, 5'b00000, 0, 0, 0));
        tbl.push_back(v(0, 5'b10011, 0, 5'b00001, 0, 1, 0));
        tbl.push_back(v(0, 5'b10011, 1, 5'b00001, 0, 1, 0));
        tbl.push_back(v(0, 5'b10011, 1, 5'b00001, 0, 1, 0));
        tbl.push_back(v(0, 5'b10010, 1, 5'b00000, 0, 0, 0));
        tbl.push_back(v(0, 5'b10010, 0, 5'b00010, 1, 1, 0));
        tbl.push_back(v(0, 5'b10010, 0, 5'b00010, 1, 1, 0));
        tbl.push_back(v(0, 5'b10010, 1, 5'b00010, 1, 1, 0));
        tbl.push_back(v(0, 5'b10000, 0, 5'b00000, 1, 0, 0));
        tbl.push_back(v(0, 5'b10000, 0, 5'b10000, 4, 1, 0));
        tbl.push_back(v(0, 5'b10000, 1, 5'b10000, 4, 1, 0));
        tbl.push_back(v(0, 5'b10000, 0, 5'b10000, 4, 1, 0));
        tbl.push_back(v(0, 5'b00000, 0, 5'b00000, 4, 0, 0));
        tbl.push_back(v(0, 5'b00000, 0, 5'b00000, 4, 0, 0));
        tbl.push_back(v(0, 5'b11111, 0, 5'b00001, 0, 1, 0));
        tbl.push_back(v(0, 5'b00000, 0, 5'b00000, 0, 0, 0));

        foreach (tbl[i]) begin
            @(negedge clk);
            rst_n = !tbl[i].rst; req = tbl[i].req; ack = tbl[i].ack;
            exp_q.push_back(tbl[i].exp);
            @(posedge clk);
            #1 check($sformatf("tbl[%0d]", i));
        end

        do_reset();
        step(5'b01000, 1'b0, "f_grant");
        repeat (15) step(5'b01010, 1'b1, "f_hold");
        check_eq("f_still_owned", int'(gnt), 5'b01000);
        step(5'b01010, 1'b1, "f_rel");
        check_eq("f_forced", int'(forced), 1);
        check_eq("f_dead", int'(gnt), 0);
        step(5'b01010, 1'b0, "f_next");
        check_eq("f_next_gnt", int'(gnt), 5'b00010);
        check_eq("f_pulse_one", int'(forced), 0);

        do_reset();
        hi = 0; fc = 0;
        for (int c = 0; c < 34; c++) begin
            step(5'b00100, 1'b1, "o2");
            hi += int'(busy);
            fc += int'(forced);
        end
        check_eq("o2_high_cycles", hi, 32);
        check_eq("o2_forced_pulses", fc, 2);
        step(5'b00100, 1'b1, "o2_regrant");
        check_eq("o2_regrant_gnt", int'(gnt), 5'b00100);

        do_reset();
        step(5'b00010, 1'b0, "ar_g1");
        step(5'b00000, 1'b0, "ar_r1");
        step(5'b01000, 1'b0, "ar_g3");
        step(5'b01000, 1'b1, "ar_hold");
        #2 rst_n = 1'b0;
        #1 check_eq("ar_gnt_async", int'(gnt), 0);
        check_eq("ar_busy_async", int'(busy), 0);
        model_reset();
        step(5'b11111, 1'b0, "ar_restart");
        check_eq("ar_restart_gnt", int'(gnt), 5'b00001);

        do_reset();
        foreach (w[i]) w[i] = 0;
        max_w = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 5; i++)
                nr[i] = !req[i] ? ($urandom_range(0, 3) == 0) :
                        (m_gnt[i] ? ($urandom_range(0, 7) != 0) : 1'b1);
            pg = gnt;
            step(nr, (c < 5000) ? ($urandom_range(0, 3) != 0) : 1'b1, "rnd");
            n_cmp++;
            if (!$onehot0(gnt) || (pg != 0 && gnt != 0 && gnt != pg)) begin
                n_bad++;
                $display("FAIL rnd_grant_shape: cycle %0d got gnt=%b after %b, want one-hot/zero with a gap", c, gnt, pg);
            end
            if (c >= 5000)
                for (int i = 0; i < 5; i++) begin
                    w[i] = (nr[i] && !gnt[i]) ? w[i] + 1 : 0;
                    if (w[i] > max_w) max_w = w[i];
                end
        end
        n_cmp++;
        if (max_w > 4 * (MAX_HOLD + 1)) begin
            n_bad++;
            $display("FAIL rnd_max_wait: got %0d cycles, want at most %0d", max_w, 4 * (MAX_HOLD + 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mo_arb.md
Name: mo_arb

Overview:
- Five-requestor round-robin arbiter that owns the DMA bus.
- Produces the one-hot grant vector consumed by the downstream output mixer; the mixer registers the grant and steers the selected channel's signal.
- Holds a grant for a whole transaction.
- Enforces a beat limit so no channel can starve the others.
- Guarantees one dead cycle between owners, so grants never overlap.

Parameters:
- NREQ, 5: number of requestors; the downstream mixer is fixed at 5.
- MAX_HOLD, 16: maximum acked beats per grant before forced release; legal range 1..31.
- CNT_W, 5: beat counter width; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- wb_clk_i  input  1  system clock; all logic on rising edge.
- wb_rst_i  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-channel bus request, level; a channel holds it high for its entire transaction.
- ack_i  input  1  slave beat acknowledge; counted only while a grant is active.
- gnt  output  NREQ  registered one-hot grant, or all zeros.
- gnt_id  output  3  registered binary index of the current or last owner.
- busy  output  1  registered; high exactly when gnt is non-zero.
- forced  output  1  one-cycle registered pulse; high in the cycle after a MAX_HOLD release.

Behaviour:
Reset:
- Reset is asynchronous, active-low on wb_rst_i, one clock (wb_clk_i).
- While reset is asserted: gnt=0, gnt_id=0, busy=0, forced=0, state=IDLE, ptr=0, cnt=0.
- Reset mid-grant drops gnt immediately, without waiting for a clock edge.

State machine (two states):
- IDLE:
  - If req is non-zero at edge k, the winner is the first set bit scanning ptr, ptr+1, … with wrap modulo NREQ.
  - At edge k: gnt is set to the winner's one-hot, gnt_id to its index, busy=1, cnt=0, state=OWN.
  - Latency is one cycle: req sampled at edge k, gnt visible after edge k.
  - If req=0, stay in IDLE; gnt_id holds its last value.
- OWN, with owner o:
  - Each edge with ack_i=1 increments cnt.
  - Release at edge k if either:
    - req[o]=0 is sampled; or
    - ack_i=1 and cnt==MAX_HOLD-1, meaning this ack is the MAX_HOLD-th beat.
  - On release at edge k: gnt=0, busy=0, state=IDLE, ptr=(o+1) mod NREQ, cnt=0.
  - forced=1 for the cycle after edge k only when the beat limit caused the release.
  - Otherwise hold gnt unchanged; changes on other req bits are ignored.
- Dead cycle: at least one cycle with gnt=0 follows every release. Re-arbitration happens at edge k+1, so the next gnt appears after edge k+1.

Boundary cases:
- req[o] dropping and a final ack in the same cycle: release, counted as a normal release, forced=0.
- Only the owner still requesting after a forced release: it wins again after the dead cycle.
- ptr wrap: after owner 4, ptr=0.
- Requests raised and dropped entirely between edges are never seen.
- The gnt=0 state outside OWN also protects the downstream mixer, which otherwise defaults to channel 0.
- No combinational path from req to gnt.

Decomposition:
- Shared package holds:
  - NREQ=5, MAX_HOLD default, CNT_W;
  - state encoding: IDLE=1'b0, OWN=1'b1;
  - gnt_id width of 3.
- One combinational sub-module, mo_rr_pick:
  - inputs: req[NREQ-1:0] and ptr[2:0];
  - outputs: one-hot pick, binary index, any.
  - Implemented by doubling the req vector, rotating it by ptr, then a find-first.
  - Unit-testable standalone.

Test Plan:
- Reset, then req=5'b00100 held -> gnt=5'b00100 one edge after the first sampled req; gnt_id=2; busy=1.
- req=5'b10011 simultaneously from reset, each dropping its bit 3 cycles after its grant -> grant order 0, 1, 4; exactly one gnt=0 cycle between owners; ptr ends at 0.
- Owner 3 holds req with ack_i=1 every cycle, MAX_HOLD=16 -> gnt released at the 16th ack; forced=1 for one cycle; if req[1] is also pending, gnt=5'b00010 next.
- Owner 2 alone requesting with continuous acks -> gnt high 16 cycles, low 1 cycle, high again; forced pulses each release.
- wb_rst_i driven low mid-transaction, between clock edges -> gnt=0 and busy=0 immediately; after release, ptr=0 and arbitration restarts from channel 0.
- Randomised req/ack over 10k cycles -> gnt always one-hot or zero, never changes owner without an intervening zero cycle, and no requestor waits more than 4×(MAX_HOLD+1) cycles.
